// File: rtl/mask_rd_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mask_rd_arb
// Purpose  : Two-requester round-robin burst read arbiter for the pattern
//            memory. Accepts one burst at a time and issues one read per
//            cycle. Each returned word goes back to the requester that owns
//            the burst, one cycle after its read.
// Revision : 1.0 - initial release
// ============================================================================
module mask_rd_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] dout,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_last,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_last,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;              // requester favoured on a tie
  logic              owner_q, owner_d;        // requester owning the burst
  logic [ADDR_W-1:0] start_q, start_d;        // latched burst start address
  logic [LEN_W-1:0]  len_q, len_d;            // latched beats minus one
  logic [LEN_W-1:0]  beat_q, beat_d;          // index of the read being issued
  logic              rsp_valid_q, rsp_valid_d; // a read was issued last cycle
  logic              rsp_last_q, rsp_last_d;   // that read was the final one
  logic              rsp_owner_q, rsp_owner_d; // who that read belongs to

  logic              grant0;
  logic              grant1;

  // Arbitration: only in IDLE; on a tie the round-robin pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || !rr_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // Ready is gated by rst_n at the output only, so reset never feeds a flop D input.
  assign req0_ready = grant0 && rst_n;
  assign req1_ready = grant1 && rst_n;

  // Next-state, burst sequencing and memory read interface.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    start_d     = start_q;
    len_d       = len_q;
    beat_d      = beat_q;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_owner_d = owner_q;
    ren         = 1'b0;
    raddr       = '0;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          start_d = grant1 ? req1_addr : req0_addr;
          len_d   = grant1 ? req1_len  : req0_len;
          owner_d = grant1;
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        ren         = 1'b1;
        raddr       = start_q + ADDR_W'(beat_q);
        rsp_valid_d = 1'b1;
        rsp_last_d  = (beat_q == len_q);
        if (beat_q == len_q) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pipeline registers; reset aborts any burst and drops in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      start_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      start_q     <= start_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // Route the returning word to the owner; non-owner outputs stay at zero.
  always_comb begin
    rsp0_valid = rsp_valid_q && !rsp_owner_q;
    rsp1_valid = rsp_valid_q &&  rsp_owner_q;
    rsp0_last  = rsp_last_q  && !rsp_owner_q;
    rsp1_last  = rsp_last_q  &&  rsp_owner_q;
    rsp0_data  = rsp0_valid ? dout : '0;
    rsp1_data  = rsp1_valid ? dout : '0;
    busy       = (state_q == BURST) || rsp_valid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mask_rd_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mask_rd_arb
// Purpose  : Self-checking bench for mask_rd_arb: directed scenarios plus
//            random bursts against a burst-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mask_rd_arb;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;

  // {ren, raddr, ready0, ready1, busy, rsp0 v/l/d, rsp1 v/l/d}
  typedef logic [151:0] obs_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [LEN_W-1:0]  req0_len = '0, req1_len = '0;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] dout;
  logic              rsp0_valid, rsp0_last, rsp1_valid, rsp1_last;
  logic [DATA_W-1:0] rsp0_data, rsp1_data;
  logic              busy;

  logic [DATA_W-1:0] mem [0:65535];
  int                n_checks = 0;
  int                n_pass   = 0;
  logic              exp_rr   = 1'b0;
  obs_t              o, e;

  mask_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_len(req1_len),
    .ren(ren), .raddr(raddr), .dout(dout),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_last(rsp0_last),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_last(rsp1_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: word at raddr one cycle after ren, garbage otherwise.
  always @(posedge clk) dout <= ren ? mem[raddr] : {$urandom, $urandom};

  function automatic obs_t obs();
    return {ren, raddr, req0_ready, req1_ready, busy,
            rsp0_valid, rsp0_last, rsp0_data, rsp1_valid, rsp1_last, rsp1_data};
  endfunction

  function automatic obs_t idle_obs(logic r0, logic r1);
    return {1'b0, 16'h0, r0, r1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0};
  endfunction

  // Expected outputs k cycles after a burst (owner, start, len) was accepted:
  // reads on k = 0..len, the word for read k-1 returned on cycle k.
  function automatic obs_t burst_obs(logic owner, logic [15:0] start, int len, int k,
                                     logic r0, logic r1);
    logic        e_ren, bv, bl;
    logic [15:0] e_addr, baddr;
    logic [63:0] bd;
    e_ren  = (k <= len);
    e_addr = e_ren ? start + 16'(k) : 16'h0;
    bv     = (k >= 1) && (k <= len + 1);
    bl     = bv && (k - 1 == len);
    baddr  = start + 16'(k - 1);
    bd     = bv ? mem[baddr] : 64'h0;
    return {e_ren, e_addr, r0, r1, 1'b1,
            bv && !owner, bl && !owner, (bv && !owner) ? bd : 64'h0,
            bv && owner,  bl && owner,  (bv && owner)  ? bd : 64'h0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1 o = obs(); e = idle_obs(1'b0, 1'b0); n_checks++;
    if (o !== e) $display("FAIL reset_hold got=%h exp=%h", o, e); else n_pass++;
    @(negedge clk);
    #1 o = obs(); n_checks++;
    if (o !== e) $display("FAIL reset_hold2 got=%h exp=%h", o, e); else n_pass++;
    rst_n = 1'b1;
    #1 o = obs(); e = idle_obs(1'b1, 1'b0); n_checks++;
    if (o !== e) $display("FAIL reset_release_rr0 got=%h exp=%h", o, e); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 o = obs(); e = idle_obs(1'b0, 1'b0); n_checks++;
    if (o !== e) $display("FAIL reset_idle got=%h exp=%h", o, e); else n_pass++;
    exp_rr = 1'b0;
  endtask

  task automatic test_single_burst();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 16'h0010; req0_len = 8'd3;
    #1 o = obs(); e = idle_obs(1'b1, 1'b0); n_checks++;
    if (o !== e) $display("FAIL single_accept got=%h exp=%h", o, e); else n_pass++;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      req0_valid = 1'b0; req0_addr = 16'($urandom); req0_len = 8'($urandom);
      #1 o = obs(); e = burst_obs(1'b0, 16'h0010, 3, k, 1'b0, 1'b0); n_checks++;
      if (o !== e) $display("FAIL single_k%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    @(negedge clk);
    #1 o = obs(); e = idle_obs(1'b0, 1'b0); n_checks++;
    if (o !== e) $display("FAIL single_done got=%h exp=%h", o, e); else n_pass++;
    exp_rr = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a0, a1, a2, a3;
    do_reset();
    a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom); a3 = 16'($urandom);
    // Simultaneous after reset: requester 0 first, requester 1 waits.
    req0_valid = 1'b1; req0_addr = a0; req0_len = 8'd2;
    req1_valid = 1'b1; req1_addr = a1; req1_len = 8'd1;
    #1 o = obs(); e = idle_obs(1'b1, 1'b0); n_checks++;
    if (o !== e) $display("FAIL b2b_first_grant got=%h exp=%h", o, e); else n_pass++;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #1 o = obs(); e = burst_obs(1'b0, a0, 2, k, 1'b0, k == 3); n_checks++;
      if (o !== e) $display("FAIL b2b_b0_k%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    // Requester 1 burst; at its idle cycle both request again -> requester 0.
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      req1_valid = (k == 2); req0_valid = (k == 2);
      req0_addr = a2; req0_len = 8'd0; req1_addr = a3; req1_len = 8'd0;
      #1 o = obs(); e = burst_obs(1'b1, a1, 1, k, k == 2, 1'b0); n_checks++;
      if (o !== e) $display("FAIL b2b_b1_k%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    // Requester 0 served; both request again -> requester 1 this time.
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      req0_valid = (k == 1); req1_valid = (k == 1);
      #1 o = obs(); e = burst_obs(1'b0, a2, 0, k, 1'b0, k == 1); n_checks++;
      if (o !== e) $display("FAIL b2b_b2_k%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1 o = obs(); e = burst_obs(1'b1, a3, 0, k, 1'b0, 1'b0); n_checks++;
      if (o !== e) $display("FAIL b2b_b3_k%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    exp_rr = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 16'hFFFE; req1_len = 8'd3;
    #1 o = obs(); e = idle_obs(1'b0, 1'b1); n_checks++;
    if (o !== e) $display("FAIL wrap_accept got=%h exp=%h", o, e); else n_pass++;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      #1 o = obs(); e = burst_obs(1'b1, 16'hFFFE, 3, k, 1'b0, 1'b0); n_checks++;
      if (o !== e) $display("FAIL wrap_k%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    exp_rr = 1'b0;
  endtask

  task automatic test_len0();
    logic [15:0] a;
    a = 16'($urandom);
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = a; req0_len = 8'd0;
    #1 o = obs(); e = idle_obs(1'b1, 1'b0); n_checks++;
    if (o !== e) $display("FAIL len0_accept got=%h exp=%h", o, e); else n_pass++;
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = (k == 1);
      #1 o = obs(); e = burst_obs(1'b0, a, 0, k, 1'b0, k == 1); n_checks++;
      if (o !== e) $display("FAIL len0_k%0d got=%h exp=%h", k, o, e); else n_pass++;
      req1_valid = 1'b0;
    end
    @(negedge clk);
    #1 o = obs(); e = idle_obs(1'b0, 1'b0); n_checks++;
    if (o !== e) $display("FAIL len0_idle got=%h exp=%h", o, e); else n_pass++;
    exp_rr = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] a;
    a = 16'($urandom);
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = a; req0_len = 8'd7;
    #1 o = obs(); e = idle_obs(1'b1, 1'b0); n_checks++;
    if (o !== e) $display("FAIL rmid_accept got=%h exp=%h", o, e); else n_pass++;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #1 o = obs(); e = burst_obs(1'b0, a, 7, k, 1'b0, 1'b0); n_checks++;
      if (o !== e) $display("FAIL rmid_k%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1 o = obs(); e = idle_obs(1'b0, 1'b0); n_checks++;
    if (o !== e) $display("FAIL rmid_async got=%h exp=%h", o, e); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 o = obs(); e = idle_obs(1'b1, 1'b0); n_checks++;
    if (o !== e) $display("FAIL rmid_rr0 got=%h exp=%h", o, e); else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 o = obs(); e = idle_obs(1'b0, 1'b0); n_checks++;
      if (o !== e) $display("FAIL rmid_stray_%0d got=%h exp=%h", k, o, e); else n_pass++;
    end
    exp_rr = 1'b0;
  endtask

  task automatic test_random_bursts();
    logic        v0, v1, w;
    logic [15:0] a0, a1, st;
    int          l0, l1, ln;
    for (int n = 0; n < 1000; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      if (($urandom & 1) == 1) begin v1 = ~v0 | v1; end
      a0 = 16'($urandom); a1 = 16'($urandom);
      l0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      l1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
      w  = (v0 && v1) ? exp_rr : v1;
      st = w ? a1 : a0;
      ln = w ? l1 : l0;
      @(negedge clk);
      req0_valid = v0; req0_addr = a0; req0_len = 8'(l0);
      req1_valid = v1; req1_addr = a1; req1_len = 8'(l1);
      #1 o = obs(); e = idle_obs(!w, w); n_checks++;
      if (o !== e) $display("FAIL rnd_grant n=%0d got=%h exp=%h", n, o, e); else n_pass++;
      for (int k = 0; k <= ln + 1; k++) begin
        @(negedge clk);
        req0_valid = (k <= ln) ? 1'($urandom) : 1'b0;
        req1_valid = (k <= ln) ? 1'($urandom) : 1'b0;
        req0_addr = 16'($urandom); req0_len = 8'($urandom);
        req1_addr = 16'($urandom); req1_len = 8'($urandom);
        #1 o = obs(); e = burst_obs(w, st, ln, k, 1'b0, 1'b0); n_checks++;
        if (o !== e) $display("FAIL rnd_beat n=%0d k=%0d got=%h exp=%h", n, k, o, e); else n_pass++;
      end
      exp_rr = !w;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_wrap();
    test_len0();
    test_reset_mid_burst();
    test_random_bursts();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mask_rd_arb.md
MASK_RD_ARB -- requirements
Module: mask_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, pattern-memory word-address width.
REQ-002 SHALL have parameter DATA_W, default 64, pattern-memory word width.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width (encodes beats minus one).
REQ-004 SHALL have port clk, input, 1, single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports req0_valid / req1_valid, input, 1, burst request from requester 0/1.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1, burst request accepted this cycle.
REQ-008 SHALL have ports req0_addr / req1_addr, input, ADDR_W, burst start word address.
REQ-009 SHALL have ports req0_len / req1_len, input, LEN_W, beats minus one (0 = 1 beat, 255 = 256 beats).
REQ-010 SHALL have port ren, output, 1, memory read enable.
REQ-011 SHALL have port raddr, output, ADDR_W, memory read address.
REQ-012 SHALL have port dout, input, DATA_W, memory read data, valid exactly one cycle after ren.
REQ-013 SHALL have ports rsp0_valid / rsp1_valid, output, 1, response beat for requester 0/1.
REQ-014 SHALL have ports rsp0_data / rsp1_data, output, DATA_W, response data.
REQ-015 SHALL have ports rsp0_last / rsp1_last, output, 1, final beat of the burst.
REQ-016 SHALL have port busy, output, 1, high while in BURST or while a response beat is outstanding.

Function
REQ-017 SHALL implement FSM with states IDLE and BURST.
REQ-018 In IDLE, SHALL assert exactly one reqN_ready (combinational) for the valid requester; if both are valid, SHALL grant the requester indicated by round-robin pointer rr.
REQ-019 A request is accepted when reqN_valid && reqN_ready; SHALL then latch addr, len, and owner, and go to BURST on the next edge.
REQ-020 SHALL never assert reqN_ready in BURST.
REQ-021 In BURST, SHALL assert ren every cycle with raddr = latched start + beat index, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-022 SHALL issue exactly len+1 reads per burst, then return to IDLE after the last read cycle.
REQ-023 On burst completion, SHALL set rr to the other requester (the one not served).
REQ-024 SHALL leave one IDLE cycle between consecutive bursts; ren SHALL be 0 in that cycle.
REQ-025 SHALL drive ren = 0 and raddr = 0 whenever not in BURST.
REQ-026 SHALL assert rspN_valid for the burst owner one cycle after each ren, with rspN_data = dout in that cycle.
REQ-027 SHALL assert rspN_last together with rspN_valid on the beat corresponding to the final read only.
REQ-028 SHALL hold non-owner rsp valid/last at 0 and rsp data at 0 when its valid is low.
REQ-029 Responses SHALL have no backpressure; consumers accept every beat.
REQ-030 SHALL ignore request fields that change while a request is not being accepted.

Reset
REQ-031 On rst_n low, SHALL asynchronously enter IDLE and clear ren, raddr, all rsp outputs, busy, and the beat counter; rr SHALL reset to requester 0.
REQ-032 Reset mid-burst SHALL abort the burst; the in-flight beat SHALL NOT be delivered after reset release.
REQ-033 SHALL deassert all reqN_ready while rst_n is low.

Verification
REQ-034 Reset release; req0 addr=0x0010, len=3 -> ren high for 4 cycles, raddr 0x0010..0x0013; rsp0_valid for 4 cycles lagging by 1; rsp0_last on 4th beat; rsp1_valid never high.
REQ-035 Both valid in the same cycle after reset -> req0 granted first; req1 granted on the next IDLE cycle; rr alternates on subsequent simultaneous requests.
REQ-036 req1 addr=0xFFFE, len=3 -> raddr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-037 len=0 -> exactly one read; rsp valid and last both high in the same single cycle; FSM back in IDLE next cycle.
REQ-038 Assert rst_n low in the 3rd read cycle of a len=7 burst -> ren and all rsp outputs low immediately; after release, IDLE with rr=0 and no stray rsp beat.
REQ-039 Memory model returns mem[raddr] one cycle after ren: check all rsp data against the model for 1000 random bursts from both requesters.
